// File: rtl/memory_stage.sv
// Memory pipeline stage: sits between execute and write-back. LOAD/STORE
// access an internal little-endian word array with MEM_LATENCY cycles of
// latency and stall upstream while in flight; other ops pass through in
// one cycle. Words are 4 bytes (addr[1:0] is the byte lane).

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 3
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef STORE
`define STORE 7'b0100011
`endif

module memory_stage #(
  parameter int DWIDTH         = 32,
  parameter int DEPTH_LOG2     = 8,
  parameter int MEM_LATENCY    = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ms_clk,
  input  logic                      ms_rst,
  input  logic                      ms_i_ce,
  input  logic [`OPCODE_WIDTH-1:0]  ms_i_opcode,
  input  logic [`FUNCT_WIDTH-1:0]   ms_i_funct,
  input  logic [DWIDTH-1:0]         ms_i_alu_value,
  input  logic [DWIDTH-1:0]         ms_i_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ms_i_rd_addr,
  input  logic                      ms_i_regwrite,
  output logic                      ms_o_ce,
  output logic [DWIDTH-1:0]         ms_o_alu_value,
  output logic [DWIDTH-1:0]         ms_o_load_data,
  output logic [REG_ADDR_WIDTH-1:0] ms_o_rd_addr,
  output logic                      ms_o_regwrite,
  output logic                      ms_o_mem_to_reg,
  output logic                      ms_o_stall,
  output logic                      ms_o_misaligned
);

  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [CW-1:0]             count;

  // Instruction captured at acceptance, used while BUSY
  logic                      c_store;
  logic [2:0]                c_funct;
  logic [DWIDTH-1:0]         c_addr;
  logic [DWIDTH-1:0]         c_data;
  logic [REG_ADDR_WIDTH-1:0] c_rd;
  logic                      c_rw;

  logic [DWIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                      in_mem;
  logic                      in_store;
  logic                      s_store;
  logic [2:0]                s_funct;
  logic [DWIDTH-1:0]         s_addr;
  logic [DWIDTH-1:0]         s_data;
  logic [REG_ADDR_WIDTH-1:0] s_rd;
  logic                      s_rw;
  logic                      complete;
  logic                      is_byte;
  logic                      is_half;
  logic                      misaligned;
  logic [4:0]                lane_shift;
  logic [DEPTH_LOG2-1:0]     idx;
  logic [DWIDTH-1:0]         rd_word;
  logic [DWIDTH-1:0]         shifted;
  logic [DWIDTH-1:0]         load_ext;
  logic [DWIDTH-1:0]         wdata;
  logic [DWIDTH-1:0]         wmask;
  logic [DWIDTH-1:0]         merged;
  logic                      mem_we;

  // The completing access comes from the inputs (single-cycle latency, IDLE)
  // or from the captured copy (BUSY); one datapath serves both cases.
  always_comb begin
    in_store = (ms_i_opcode == `STORE);
    in_mem   = (ms_i_opcode == `LOAD) || in_store;

    if (state == BUSY) begin
      s_store = c_store;
      s_funct = c_funct;
      s_addr  = c_addr;
      s_data  = c_data;
      s_rd    = c_rd;
      s_rw    = c_rw;
    end else begin
      s_store = in_store;
      s_funct = ms_i_funct[2:0];
      s_addr  = ms_i_alu_value;
      s_data  = ms_i_store_data;
      s_rd    = ms_i_rd_addr;
      s_rw    = ms_i_regwrite;
    end

    complete = ((state == BUSY) && (count == CW'(1))) ||
               ((state == IDLE) && ms_i_ce && in_mem && (MEM_LATENCY == 1));

    // Stores only know SB/SH; LBU/LHU codes are loads only, rest act as word
    if (s_store) begin
      is_byte = (s_funct == 3'b000);
      is_half = (s_funct == 3'b001);
    end else begin
      is_byte = (s_funct == 3'b000) || (s_funct == 3'b100);
      is_half = (s_funct == 3'b001) || (s_funct == 3'b101);
    end

    if (is_half)      misaligned = s_addr[0];
    else if (is_byte) misaligned = 1'b0;
    else              misaligned = (s_addr[1:0] != 2'b00);

    lane_shift = {s_addr[1:0], 3'b000};
    idx        = s_addr[DEPTH_LOG2+1:2];
    rd_word    = mem[idx];
    shifted    = rd_word >> lane_shift;

    if (is_byte)
      load_ext = {{(DWIDTH-8){~s_funct[2] & shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_ext = {{(DWIDTH-16){~s_funct[2] & shifted[15]}}, shifted[15:0]};
    else
      load_ext = rd_word;

    if (is_byte) begin
      wdata = DWIDTH'({4{s_data[7:0]}});
      wmask = DWIDTH'(8'hFF) << lane_shift;
    end else if (is_half) begin
      wdata = DWIDTH'({2{s_data[15:0]}});
      wmask = DWIDTH'(16'hFFFF) << lane_shift;
    end else begin
      wdata = s_data;
      wmask = '1;
    end
    merged = (rd_word & ~wmask) | (wdata & wmask);

    // Gated by reset so an abandoned access never lands in memory
    mem_we = complete && s_store && !misaligned && !ms_rst;
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge ms_clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  // Control FSM with registered outputs
  always_ff @(posedge ms_clk or posedge ms_rst) begin
    if (ms_rst) begin
      state           <= IDLE;
      count           <= '0;
      c_store         <= 1'b0;
      c_funct         <= '0;
      c_addr          <= '0;
      c_data          <= '0;
      c_rd            <= '0;
      c_rw            <= 1'b0;
      ms_o_ce         <= 1'b0;
      ms_o_alu_value  <= '0;
      ms_o_load_data  <= '0;
      ms_o_rd_addr    <= '0;
      ms_o_regwrite   <= 1'b0;
      ms_o_mem_to_reg <= 1'b0;
      ms_o_stall      <= 1'b0;
      ms_o_misaligned <= 1'b0;
    end else begin
      ms_o_ce         <= 1'b0;
      ms_o_alu_value  <= '0;
      ms_o_load_data  <= '0;
      ms_o_rd_addr    <= '0;
      ms_o_regwrite   <= 1'b0;
      ms_o_mem_to_reg <= 1'b0;
      ms_o_stall      <= 1'b0;
      ms_o_misaligned <= 1'b0;

      if (complete) begin
        ms_o_ce         <= 1'b1;
        ms_o_alu_value  <= s_addr;
        ms_o_rd_addr    <= s_rd;
        ms_o_misaligned <= misaligned;
        ms_o_regwrite   <= !s_store && !misaligned && s_rw;
        ms_o_mem_to_reg <= !s_store;
        ms_o_load_data  <= (!s_store && !misaligned) ? load_ext : '0;
      end else if ((state == IDLE) && ms_i_ce && !in_mem) begin
        ms_o_ce         <= 1'b1;
        ms_o_alu_value  <= ms_i_alu_value;
        ms_o_rd_addr    <= ms_i_rd_addr;
        ms_o_regwrite   <= ms_i_regwrite;
      end

      case (state)
        IDLE: begin
          if (ms_i_ce && in_mem && (MEM_LATENCY > 1)) begin
            state      <= BUSY;
            count      <= CW'(MEM_LATENCY - 1);
            ms_o_stall <= 1'b1;
            c_store    <= in_store;
            c_funct    <= ms_i_funct[2:0];
            c_addr     <= ms_i_alu_value;
            c_data     <= ms_i_store_data;
            c_rd       <= ms_i_rd_addr;
            c_rw       <= ms_i_regwrite;
          end
        end
        BUSY: begin
          if (count == CW'(1)) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count      <= count - CW'(1);
            ms_o_stall <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected results are modelled and queued
// at acceptance and compared when ms_o_ce is observed.

module tb_memory_stage;

  localparam int         L        = 2;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct = '0;
  logic [31:0] alu = '0;
  logic [31:0] sdata = '0;
  logic [4:0]  rd = '0;
  logic        rw = 1'b0;

  logic        o_ce, o_rw, o_m2r, o_stall, o_mis;
  logic [31:0] o_alu, o_ld;
  logic [4:0]  o_rd;

  memory_stage #(.DWIDTH(32), .DEPTH_LOG2(8), .MEM_LATENCY(L), .REG_ADDR_WIDTH(5)) dut (
    .ms_clk(clk), .ms_rst(rst), .ms_i_ce(ce), .ms_i_opcode(opcode),
    .ms_i_funct(funct), .ms_i_alu_value(alu), .ms_i_store_data(sdata),
    .ms_i_rd_addr(rd), .ms_i_regwrite(rw), .ms_o_ce(o_ce),
    .ms_o_alu_value(o_alu), .ms_o_load_data(o_ld), .ms_o_rd_addr(o_rd),
    .ms_o_regwrite(o_rw), .ms_o_mem_to_reg(o_m2r), .ms_o_stall(o_stall),
    .ms_o_misaligned(o_mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mis;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [0:255];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned stall_cycles = 0;
  int unsigned mem_ops = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one instruction, applied to the model memory
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [4:0] r, input logic w);
    exp_t        e;
    int          sz;
    logic        st;
    logic [31:0] word, sh, tmp;
    e.alu = a; e.rd = r; e.ld = '0; e.rw = 1'b0; e.m2r = 1'b0; e.mis = 1'b0; e.cyc = 0;
    if (op != OP_LOAD && op != OP_STORE) begin
      e.rw = w;
      return e;
    end
    st = (op == OP_STORE);
    if (st) sz = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    else    sz = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    e.mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    word = mdl[a[9:2]];
    sh   = word >> (8 * a[1:0]);
    if (!st) begin
      e.m2r = 1'b1;
      if (!e.mis) begin
        e.rw = w;
        if (sz == 1)      e.ld = (f == 3'd4) ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (sz == 2) e.ld = (f == 3'd5) ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else              e.ld = word;
      end
    end else if (!e.mis) begin
      tmp = word;
      for (int k = 0; k < sz; k++) tmp[8*(a[1:0]+k) +: 8] = d[8*k +: 8];
      mdl[a[9:2]] = tmp;
    end
    return e;
  endfunction

  // Must be entered just after a rising edge; returns just after acceptance
  task automatic send(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] r, input logic w,
                      input bit track);
    exp_t        e;
    logic        st;
    int unsigned waited = 0;
    bit          is_mem;
    ce = 1'b1; opcode = op; funct = f; alu = a; sdata = d; rd = r; rw = w;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    do begin
      @(negedge clk);
      st = o_stall;
      @(posedge clk);
      waited++;
    end while (st && waited < 20);
    #1;
    if (st) begin
      check("accept_timeout", 32'(st), 32'd0);
      return;
    end
    if (track) begin
      e = model(op, f, a, d, r, w);
      e.cyc = cyc - 1 + (is_mem ? L - 1 : 0) + 1;
      sb.push_back(e);
      if (is_mem) mem_ops++;
    end
  endtask

  task automatic idle_cycle();
    ce = 1'b0; opcode = OP_ALU; funct = '0; alu = '0; sdata = '0; rd = '0; rw = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned w = 0;
    ce = 1'b0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: scoreboard compare on ce, zero check on idle bubbles
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_stall) stall_cycles++;
      if (o_ce) begin
        if (sb.size() == 0) begin
          check("spurious_ce", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("alu_value", o_alu, e.alu);
          check("load_data", o_ld, e.ld);
          check("rd_addr", 32'(o_rd), 32'(e.rd));
          check("regwrite", 32'(o_rw), 32'(e.rw));
          check("mem_to_reg", 32'(o_m2r), 32'(e.m2r));
          check("misaligned", 32'(o_mis), 32'(e.mis));
          check("ce_cycle", cyc, e.cyc);
        end
      end else if (!o_stall) begin
        check("bubble_zero", {o_alu | o_ld}, 32'd0);
        check("bubble_flags", {27'd0, o_rd} | 32'({o_rw, o_m2r, o_mis}), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = '0;

    #12;
    check("rst_ce", 32'(o_ce), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_data", o_alu | o_ld, 32'd0);
    check("rst_flags", 32'({o_rw, o_m2r, o_mis}) | 32'(o_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word store then load
    send(OP_STORE, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1, 1'b1, 1'b1);
    send(OP_LOAD,  3'd2, 32'h10, 32'h0,       5'd3, 1'b1, 1'b1);

    // Byte store and sign/zero extension
    send(OP_STORE, 3'd2, 32'h20, 32'h0,       5'd0, 1'b0, 1'b1);
    send(OP_STORE, 3'd0, 32'h21, 32'h00000080, 5'd2, 1'b1, 1'b1);
    send(OP_LOAD,  3'd0, 32'h21, 32'h0,       5'd4, 1'b1, 1'b1);
    send(OP_LOAD,  3'd4, 32'h21, 32'h0,       5'd5, 1'b1, 1'b1);
    send(OP_LOAD,  3'd2, 32'h20, 32'h0,       5'd6, 1'b1, 1'b1);
    send(OP_LOAD,  3'd1, 32'h20, 32'h0,       5'd7, 1'b1, 1'b1);

    // Misaligned accesses
    send(OP_LOAD,  3'd1, 32'h13, 32'h0,       5'd8, 1'b1, 1'b1);
    send(OP_STORE, 3'd2, 32'h12, 32'h55555555, 5'd9, 1'b1, 1'b1);
    send(OP_LOAD,  3'd2, 32'h10, 32'h0,       5'd10, 1'b1, 1'b1);

    // Back-to-back pass-through ops
    idle_cycle();
    send(OP_ALU, 3'd0, 32'd5, 32'h0, 5'd11, 1'b1, 1'b1);
    send(OP_ALU, 3'd0, 32'd6, 32'h0, 5'd12, 1'b0, 1'b1);
    send(OP_ALU, 3'd0, 32'd7, 32'h0, 5'd13, 1'b1, 1'b1);
    idle_cycle();

    // Address wrap and undefined funct
    send(OP_STORE, 3'd2, 32'h400, 32'h1234, 5'd14, 1'b1, 1'b1);
    send(OP_LOAD,  3'd2, 32'h000, 32'h0,    5'd15, 1'b1, 1'b1);
    send(OP_LOAD,  3'd7, 32'h010, 32'h0,    5'd16, 1'b1, 1'b1);

    drain();
    check("stall_cycles", stall_cycles, mem_ops * (L - 1));

    // Reset during an in-flight store
    @(posedge clk);
    #1;
    send(OP_STORE, 3'd2, 32'h40, 32'h11112222, 5'd17, 1'b1, 1'b1);
    send(OP_STORE, 3'd2, 32'h40, 32'hCAFEF00D, 5'd18, 1'b1, 1'b0);
    ce = 1'b0;
    check("busy_before_rst", 32'(o_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ce", 32'(o_ce), 32'd0);
    check("rst_mid_stall", 32'(o_stall), 32'd0);
    check("rst_mid_data", o_alu | o_ld, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(OP_LOAD, 3'd2, 32'h40, 32'h0, 5'd19, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage, upstream of write-back.
- Consumes the registered ALU result (the effective address for LOAD/STORE), opcode, funct, store data and destination register.
- Performs byte/half/word data-memory access on an internal word array with a configurable multi-cycle latency, stalling upstream while busy.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- DWIDTH, 32, data/address width.
- DEPTH_LOG2, 8, log2 of data-memory words (256 x 32-bit).
- MEM_LATENCY, 2, cycles from acceptance to result for LOAD/STORE (>=1).
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- ms_clk  in  1  clock, rising edge.
- ms_rst  in  1  reset, asynchronous, active-high.
- ms_i_ce  in  1  valid instruction from execute.
- ms_i_opcode  in  `OPCODE_WIDTH  opcode (`LOAD/`STORE select memory access).
- ms_i_funct  in  `FUNCT_WIDTH  access size in bits [2:0]: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- ms_i_alu_value  in  DWIDTH  ALU result / effective byte address.
- ms_i_store_data  in  DWIDTH  rt data for stores.
- ms_i_rd_addr  in  REG_ADDR_WIDTH  destination register.
- ms_i_regwrite  in  1  destination write enable.
- ms_o_ce  out  1  result valid to write-back (one pulse per instruction).
- ms_o_alu_value  out  DWIDTH  ALU result passed through.
- ms_o_load_data  out  DWIDTH  extended load data.
- ms_o_rd_addr  out  REG_ADDR_WIDTH  destination register.
- ms_o_regwrite  out  1  write enable (0 for stores and misaligned accesses).
- ms_o_mem_to_reg  out  1  1 = write-back selects load data.
- ms_o_stall  out  1  upstream must hold its registers.
- ms_o_misaligned  out  1  misaligned access flag, qualified by ms_o_ce.

Behaviour:
- Reset (async, ms_rst=1): FSM to IDLE, counter 0, all outputs 0. Memory contents are not cleared. An in-flight access is abandoned with no write.
- FSM states: IDLE and BUSY.
- IDLE, ms_i_ce=1, non-memory op:
  - Next edge: ms_o_ce=1, alu_value/rd_addr/regwrite passed through, load_data=0, mem_to_reg=0, misaligned=0.
- IDLE, ms_i_ce=1, LOAD/STORE:
  - All inputs captured at the acceptance edge.
  - MEM_LATENCY=1: access completes at that same edge, no stall.
  - MEM_LATENCY>1: go to BUSY with counter=MEM_LATENCY-1; ms_o_ce=0 until completion.
- BUSY:
  - ms_o_stall=1 (registered, no combinational path from inputs); ms_i_ce is ignored.
  - Counter decrements each edge. At the edge where the counter is 1, the access completes, outputs are registered with ms_o_ce=1, and state returns to IDLE.
  - Result is visible MEM_LATENCY cycles after the acceptance cycle; stall is low in that result cycle.
- IDLE, ms_i_ce=0: next edge ms_o_ce=0 and all other outputs 0 (bubble).
- Addressing: word index = addr[DEPTH_LOG2+1:2]; upper bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
- Byte lane is addr[1:0]; halfword lane is addr[1]; little-endian.
- Loads:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - mem_to_reg=1; regwrite=ms_i_regwrite.
- Stores:
  - Write only the selected byte lanes (SB low byte, SH low half, SW full word) at the completion edge.
  - regwrite=0, mem_to_reg=0, load_data=0.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0):
  - No memory write, load_data=0, regwrite=0, misaligned=1 with ms_o_ce.
  - Latency is unchanged.
- Undefined funct[2:0] codes are treated as LW/SW.
- A load following a store to the same address returns the stored value; the store is written before the load is accepted.

Test Plan:
- MEM_LATENCY=2; SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ms_o_stall high exactly 1 cycle per access; load_data=0xDEADBEEF, mem_to_reg=1, ms_o_ce pulses twice.
- SB 0x80 to addr 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 shows 0x8000 in byte 1 only.
- LH at addr 0x13 -> misaligned=1, regwrite=0, load_data=0; an SW at 0x12 leaves memory unchanged (verified by a subsequent LW).
- Back-to-back non-memory ops (alu_value 5, 6, 7) with MEM_LATENCY=2 -> ms_o_ce high 3 consecutive cycles, stall never asserted, values passed in order.
- Address wrap, DEPTH_LOG2=8: SW 0x400 data 0x1234 -> LW 0x000 returns 0x1234.
- Assert ms_rst during BUSY of an SW -> outputs 0 immediately, stall drops, target word unchanged after reset release.
